if_fetch_redirect: RTL and testbench
====================================

Name: if_fetch_redirect

Overview:
- Instruction-fetch front end of the 5-stage MIPS pipeline: owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- It is the consumer of the ID-stage redirect signals PCSrc and Jump. On a taken branch or jump it loads the target, flushes IF/ID, and discards any wrong-path fetch still in flight.
- At most one instruction-memory request is outstanding at any time.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID on a bubble or flush

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
PCSrc  input  1  branch taken, resolved in ID
Jump  input  1  jump in ID
Branch_Target  input  32  branch target address
Jump_Target  input  32  jump target address
If_Id_Write  input  1  0 = ID stalled, hold IF/ID (from hazard unit)
Imem_Req  output  1  fetch request valid
Imem_Addr  output  32  fetch address, equals current PC
Imem_Ack  input  1  request accepted this cycle
Imem_Rvalid  input  1  read data valid
Imem_Rdata  input  32  fetched instruction
If_Id_Instr  output  32  IF/ID instruction
If_Id_PC4  output  32  IF/ID PC+4
If_Id_Valid  output  1  IF/ID holds a real instruction
If_Id_Flush  output  1  combinational, Jump | PCSrc

Behaviour:
- Reset, asynchronous, while rst_n=0: PC=RESET_PC, If_Id_Instr=NOP_INSTR, If_Id_PC4=0, If_Id_Valid=0, skid buffer empty, state=REQ, Imem_Req=0.
- Imem_Req=1 only in state REQ after the first clock following reset release. Imem_Addr=PC at all times.
- Redirect (redir) = Jump | PCSrc.
  - Target = Jump_Target if Jump, else Branch_Target. Jump has priority when both are high.
  - The redirect is taken in every state, regardless of If_Id_Write.
  - On redir at a clock edge: PC <= target; If_Id_Valid <= 0; If_Id_Instr <= NOP_INSTR; skid buffer cleared.
- States:
  - REQ:
    - Ack & !redir: go to WAIT.
    - Ack & redir: go to DISCARD, because the accepted address is wrong-path.
    - !Ack & redir: stay in REQ; the address switches to the target next cycle.
  - WAIT:
    - Rvalid & !redir & If_Id_Write: IF/ID <= {Rdata, PC+4, valid=1}; PC <= PC+4; go to REQ.
    - Rvalid & !redir & !If_Id_Write: Rdata goes to the skid buffer; go to HOLD. PC is not advanced.
    - Rvalid & redir: response dropped; go to REQ.
    - !Rvalid & redir: go to DISCARD.
  - HOLD:
    - If_Id_Write & !redir: IF/ID <= skid contents; PC <= PC+4; go to REQ.
    - redir: go to REQ.
    - Otherwise hold.
  - DISCARD:
    - Rvalid: data ignored; go to REQ.
    - redir in DISCARD: PC is updated and the state stays DISCARD, unless Rvalid arrives in the same cycle, which gives REQ.
- If_Id_Write=0 with no new load: IF/ID holds its value.
- If_Id_Write=1 while no fetched instruction is available: If_Id_Valid <= 0, If_Id_Instr <= NOP_INSTR (bubble).
- Arithmetic: PC+4 is a 32-bit add; wrap-around from 32'hFFFF_FFFC to 0 is allowed. Targets are used unmodified.
- Imem_Rvalid in REQ state is a protocol error and is ignored.

Optional Feature:
- Macro FETCH_STATS_EN.
- When defined, two outputs are added:
  - Redirect_Cnt [31:0]: +1 per cycle with redir.
  - Discard_Cnt [31:0]: +1 per dropped or DISCARD-state Rvalid.
- Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
- When not defined, these outputs and their counter logic are absent.

Test Plan:
- Reset release, memory with Ack=1 and Rvalid one cycle later -> Imem_Addr sequence 0x0, 0x4, 0x8; If_Id_Instr follows the memory contents; If_Id_PC4 sequence 0x4, 0x8, 0xC; Valid=1.
- PCSrc=1 with Branch_Target=0x100 during WAIT, Rvalid arriving 2 cycles later -> state DISCARD; stale data never reaches IF/ID; next Imem_Addr=0x100; If_Id_Flush=1 in the PCSrc cycle.
- Jump=1 and PCSrc=1 together, Jump_Target=0x200, Branch_Target=0x300 -> PC=0x200.
- If_Id_Write=0 when Rvalid returns 0x8C220004 -> HOLD with IF/ID unchanged. If_Id_Write=1 three cycles later -> IF/ID=0x8C220004 and fetch resumes at PC+4.
- PC=32'hFFFF_FFFC fetch completes -> next Imem_Addr=0; If_Id_PC4=0.
- rst_n asserted in WAIT with a request outstanding -> all outputs return to their reset values immediately. The first post-reset Rvalid is not loaded, because Imem_Req was 0.

Source files
------------

// File: rtl/if_fetch_redirect.sv
// if_fetch_redirect: MIPS IF stage - PC register, single-outstanding imem fetch, IF/ID register.
// Latency: a fetched word lands in IF/ID on the edge that sees Imem_Rvalid (>= 2 cycles after request).
// Backpressure: If_Id_Write=0 parks a returned word in a 1-entry skid buffer (HOLD); FETCH_STATS_EN adds counters.
module if_fetch_redirect #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCSrc,
  input  logic        Jump,
  input  logic [31:0] Branch_Target,
  input  logic [31:0] Jump_Target,
  input  logic        If_Id_Write,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ack,
  input  logic        Imem_Rvalid,
  input  logic [31:0] Imem_Rdata,
  output logic [31:0] If_Id_Instr,
  output logic [31:0] If_Id_PC4,
  output logic        If_Id_Valid,
  output logic        If_Id_Flush
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] Redirect_Cnt,
  output logic [31:0] Discard_Cnt
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DISCARD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, pc_plus4;
  logic [31:0] skid, skid_nxt;
  logic [31:0] load_dat;
  logic        load;
  logic        armed;
  logic        redir;
  logic [31:0] target;

  assign redir       = Jump | PCSrc;
  assign target      = Jump ? Jump_Target : Branch_Target;
  assign pc_plus4    = pc + 32'd4;
  assign Imem_Addr   = pc;
  assign Imem_Req    = armed && (state == S_REQ);
  assign If_Id_Flush = redir;

  // Requests are held off until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // State, PC and skid buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      skid  <= NOP_INSTR;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      skid  <= skid_nxt;
    end
  end

  // Next-state: fetch handshake, wrong-path tracking, redirect override.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    skid_nxt  = skid;
    load      = 1'b0;
    load_dat  = skid;
    case (state)
      S_REQ: begin
        // Rvalid here has no matching request and is ignored.
        if (Imem_Req && Imem_Ack) state_nxt = redir ? S_DISCARD : S_WAIT;
      end
      S_WAIT: begin
        if (Imem_Rvalid) begin
          state_nxt = S_REQ;
          if (!redir) begin
            if (If_Id_Write) begin
              load     = 1'b1;
              load_dat = Imem_Rdata;
            end else begin
              skid_nxt  = Imem_Rdata;
              state_nxt = S_HOLD;
            end
          end
        end else if (redir) begin
          state_nxt = S_DISCARD;
        end
      end
      S_HOLD: begin
        if (redir) begin
          state_nxt = S_REQ;
        end else if (If_Id_Write) begin
          load      = 1'b1;
          load_dat  = skid;
          state_nxt = S_REQ;
        end
      end
      S_DISCARD: begin
        // The response belongs to a wrong-path address.
        if (Imem_Rvalid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
    if (load) pc_nxt = pc_plus4;
    if (redir) begin
      pc_nxt   = target;
      skid_nxt = NOP_INSTR;
    end
  end

  // IF/ID register: flush beats load, load beats bubble, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      If_Id_Instr <= NOP_INSTR;
      If_Id_PC4   <= 32'h0;
      If_Id_Valid <= 1'b0;
    end else if (redir) begin
      If_Id_Instr <= NOP_INSTR;
      If_Id_Valid <= 1'b0;
    end else if (load) begin
      If_Id_Instr <= load_dat;
      If_Id_PC4   <= pc_plus4;
      If_Id_Valid <= 1'b1;
    end else if (If_Id_Write) begin
      If_Id_Instr <= NOP_INSTR;
      If_Id_Valid <= 1'b0;
    end
  end

`ifdef FETCH_STATS_EN
  logic drop;
  assign drop = Imem_Rvalid && (((state == S_WAIT) && redir) || (state == S_DISCARD));

  // Saturating event counters for redirects and discarded responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Redirect_Cnt <= 32'h0;
      Discard_Cnt  <= 32'h0;
    end else begin
      if (redir && (Redirect_Cnt != 32'hFFFF_FFFF)) Redirect_Cnt <= Redirect_Cnt + 32'd1;
      if (drop && (Discard_Cnt != 32'hFFFF_FFFF))   Discard_Cnt  <= Discard_Cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_redirect.sv
// Bench for if_fetch_redirect: directed scenarios then random traffic,
// checked every cycle against a transaction-level fetch model.
module tb_if_fetch_redirect;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCSrc = 1'b0, Jump = 1'b0;
  logic [31:0] Branch_Target = '0, Jump_Target = '0;
  logic        If_Id_Write = 1'b1;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Ack = 1'b0, Imem_Rvalid = 1'b0;
  logic [31:0] Imem_Rdata = '0;
  logic [31:0] If_Id_Instr, If_Id_PC4;
  logic        If_Id_Valid, If_Id_Flush;

  always #5 clk = ~clk;

  if_fetch_redirect #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .Jump(Jump),
    .Branch_Target(Branch_Target), .Jump_Target(Jump_Target),
    .If_Id_Write(If_Id_Write), .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr),
    .Imem_Ack(Imem_Ack), .Imem_Rvalid(Imem_Rvalid), .Imem_Rdata(Imem_Rdata),
    .If_Id_Instr(If_Id_Instr), .If_Id_PC4(If_Id_PC4), .If_Id_Valid(If_Id_Valid),
    .If_Id_Flush(If_Id_Flush)
  );

  int n_chk = 0, n_fail = 0;

  // Model: PC, one outstanding fetch (possibly wrong-path), one parked word, IF/ID.
  logic [31:0] m_pc, m_instr, m_pc4, m_held_dat;
  logic        m_valid, m_started, m_out, m_stale, m_held;

  // Memory: serves one request at a time after a random delay.
  logic        mem_busy = 1'b0;
  int unsigned mem_cnt = 0, min_dly = 0, max_dly = 0, ack_pct = 100, spur_pct = 0;
  logic [31:0] mem_addr = '0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0000_0400) return 32'h8C22_0004;
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic m_req();
    return m_started && !m_out && !m_held;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("req",   32'(Imem_Req),    32'(m_req()));
    check("addr",  Imem_Addr,        m_pc);
    check("instr", If_Id_Instr,      m_instr);
    check("pc4",   If_Id_PC4,        m_pc4);
    check("valid", 32'(If_Id_Valid), 32'(m_valid));
  endtask

  task automatic mem_pick();
    Imem_Rvalid = 1'b0;
    Imem_Rdata  = $urandom;
    if (mem_busy && mem_cnt == 0) begin
      Imem_Rvalid = 1'b1;
      Imem_Rdata  = memf(mem_addr);
    end else if (!mem_busy && $urandom_range(99) < spur_pct) begin
      Imem_Rvalid = 1'b1;
    end
    Imem_Ack = rst_n && m_req() && !mem_busy && ($urandom_range(99) < ack_pct);
  endtask

  task automatic mem_update();
    if (mem_busy) begin
      if (mem_cnt == 0) mem_busy = 1'b0;
      else mem_cnt--;
    end
    if (Imem_Ack && Imem_Req) begin
      mem_busy = 1'b1;
      mem_addr = Imem_Addr;
      mem_cnt  = $urandom_range(max_dly, min_dly);
    end
  endtask

  // One clock: drive memory, check flush, advance the model, check after the edge.
  task automatic step();
    logic        redir, acc, ret, have;
    logic [31:0] tgt, dat;
    mem_pick();
    #1;
    check("flush", 32'(If_Id_Flush), 32'(Jump | PCSrc));
    redir = Jump | PCSrc;
    tgt   = Jump ? Jump_Target : Branch_Target;
    acc   = m_req() && Imem_Ack;
    ret   = m_out && Imem_Rvalid;
    have  = 1'b0;
    dat   = '0;
    if (redir) begin
      m_pc = tgt; m_valid = 1'b0; m_instr = NOP_INSTR; m_held = 1'b0;
      if (acc) begin m_out = 1'b1; m_stale = 1'b1; end
      else if (ret) m_out = 1'b0;
      else if (m_out) m_stale = 1'b1;
    end else begin
      if (acc) begin
        m_out = 1'b1; m_stale = 1'b0;
      end else if (ret) begin
        m_out = 1'b0;
        if (!m_stale) begin
          if (If_Id_Write) begin have = 1'b1; dat = Imem_Rdata; end
          else begin m_held = 1'b1; m_held_dat = Imem_Rdata; end
        end
      end else if (m_held && If_Id_Write) begin
        have = 1'b1; dat = m_held_dat; m_held = 1'b0;
      end
      if (have) begin
        m_instr = dat; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end else if (If_Id_Write) begin
        m_valid = 1'b0; m_instr = NOP_INSTR;
      end
    end
    m_started = 1'b1;
    mem_update();
    @(negedge clk);
    check_outputs();
  endtask

  // Asynchronous reset mid-cycle; outputs must change before any clock edge.
  task automatic do_reset();
    Jump = 1'b0; PCSrc = 1'b0;
    rst_n = 1'b0;
    m_pc = RESET_PC; m_instr = NOP_INSTR; m_pc4 = '0; m_valid = 1'b0;
    m_started = 1'b0; m_out = 1'b0; m_stale = 1'b0; m_held = 1'b0; m_held_dat = '0;
    mem_pick();
    #1 check_outputs();
    mem_update();
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
  endtask

  task automatic wait_req(input int limit);
    int k = 0;
    while (!m_req() && k < limit) begin step(); k++; end
    check("wait_req", 32'(Imem_Req), 32'd1);
  endtask

  initial begin
    do_reset();

    // Back-to-back fetches from reset.
    repeat (3) step();
    check("seq0_addr", Imem_Addr, 32'h4);
    check("seq0_pc4", If_Id_PC4, 32'h4);
    check("seq0_instr", If_Id_Instr, memf(32'h0));
    check("seq0_valid", 32'(If_Id_Valid), 32'd1);
    repeat (2) step();
    check("seq1_pc4", If_Id_PC4, 32'h8);
    check("seq1_addr", Imem_Addr, 32'h8);
    repeat (2) step();
    check("seq2_pc4", If_Id_PC4, 32'hC);

    // Branch while waiting; stale response must be dropped.
    min_dly = 2; max_dly = 2;
    step();
    PCSrc = 1'b1; Branch_Target = 32'h100;
    step();
    PCSrc = 1'b0;
    check("br_req", 32'(Imem_Req), 32'd0);
    check("br_addr", Imem_Addr, 32'h100);
    repeat (2) step();
    check("br_req2", 32'(Imem_Req), 32'd1);
    check("br_valid", 32'(If_Id_Valid), 32'd0);
    min_dly = 0; max_dly = 0;

    // Jump wins over branch.
    Jump = 1'b1; PCSrc = 1'b1; Jump_Target = 32'h200; Branch_Target = 32'h300;
    step();
    Jump = 1'b0; PCSrc = 1'b0;
    check("jprio_addr", Imem_Addr, 32'h200);

    // Stalled ID parks the word, then releases it.
    wait_req(10);
    Jump = 1'b1; Jump_Target = 32'h400;
    step();
    Jump = 1'b0;
    wait_req(10);
    check("hold_addr", Imem_Addr, 32'h400);
    If_Id_Write = 1'b0;
    repeat (2) step();
    check("hold_req", 32'(Imem_Req), 32'd0);
    check("hold_instr", If_Id_Instr, NOP_INSTR);
    repeat (2) step();
    check("hold_instr2", If_Id_Instr, NOP_INSTR);
    If_Id_Write = 1'b1;
    step();
    check("rel_instr", If_Id_Instr, 32'h8C22_0004);
    check("rel_pc4", If_Id_PC4, 32'h404);
    check("rel_addr", Imem_Addr, 32'h404);

    // PC wrap-around.
    wait_req(10);
    Jump = 1'b1; Jump_Target = 32'hFFFF_FFFC;
    step();
    Jump = 1'b0;
    wait_req(10);
    check("wrap_addr0", Imem_Addr, 32'hFFFF_FFFC);
    repeat (2) step();
    check("wrap_addr", Imem_Addr, 32'h0);
    check("wrap_pc4", If_Id_PC4, 32'h0);

    // Reset with a fetch outstanding.
    min_dly = 3; max_dly = 3;
    wait_req(10);
    step();
    do_reset();
    repeat (3) step();
    check("rst_valid", 32'(If_Id_Valid), 32'd0);

    // Random traffic.
    min_dly = 0; max_dly = 3; ack_pct = 60; spur_pct = 5;
    for (int i = 0; i < 3000; i++) begin
      Jump          = ($urandom_range(99) < 5);
      PCSrc         = ($urandom_range(99) < 10);
      Jump_Target   = ($urandom_range(9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      Branch_Target = $urandom & 32'hFFFF_FFFC;
      If_Id_Write   = ($urandom_range(99) < 70);
      if ($urandom_range(499) == 0) do_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
